uart_tx_arbiter: RTL and testbench

//  Shares one byte-serial UART transmitter (data/we/ready port) between N_REQ byte-stream requesters.

---
 rtl/uart_tx_arbiter_pkg.sv | 34 +++
 rtl/uart_tx_arbiter_if.sv | 36 +++
 rtl/uart_rr_pick.sv | 64 ++++++
 rtl/uart_tx_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_pkg
// Description : Shared definitions for the UART transmitter arbiter:
//               FSM state encodings, default lock timeout, requester limit
//               and the state enum used by the arbiter FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_arbiter_pkg;

    // FSM state encodings
    localparam logic [1:0] UART_ARB_IDLE   = 2'd0;
    localparam logic [1:0] UART_ARB_LAUNCH = 2'd1;
    localparam logic [1:0] UART_ARB_DRAIN  = 2'd2;

    // Default number of idle cycles before a stalled packet lock is broken
    localparam int UART_ARB_LOCK_TIMEOUT_DEF = 1024;

    // Largest supported number of requesters
    localparam int UART_ARB_N_REQ_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = UART_ARB_IDLE,
        ST_LAUNCH = UART_ARB_LAUNCH,
        ST_DRAIN  = UART_ARB_DRAIN
    } arb_state_e;

    // Width of a requester index; at least one bit even for a single requester
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester and transmitter handshake bundle of the arbiter.
//   req_valid [N_REQ]    requester i offers a byte
//   req_data  [8*N_REQ]  byte of requester i at [8*i+7:8*i]
//   req_last  [N_REQ]    offered byte ends requester i's packet
//   req_ready [N_REQ]    one-cycle accept pulse
//   tx_data   [8]        byte to the transmitter
//   tx_we                transmitter write strobe
//   tx_ready             transmitter idle
//   master : arbiter side      slave : requesters + transmitter side
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         tx_data;
    logic               tx_we;
    logic               tx_ready;

    modport master (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_data, tx_we
    );

    modport slave (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_data, tx_we
    );
endinterface
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_pick
// Description : Combinational winner selection for the UART arbiter.
//   When locked, only the lock owner can win (if its valid is high).
//   Otherwise the first valid index at or after the pointer wins,
//   wrapping modulo N_REQ.
//   valid_i  [N_REQ]  request vector
//   ptr_i    [IW]     round-robin pointer
//   lock_i            packet lock held
//   owner_i  [IW]     lock owner index
//   found_o           a winner exists
//   onehot_o [N_REQ]  one-hot winner
//   idx_o    [IW]     winner index
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IW-1:0]    ptr_i,
    input  logic             lock_i,
    input  logic [IW-1:0]    owner_i,
    output logic             found_o,
    output logic [N_REQ-1:0] onehot_o,
    output logic [IW-1:0]    idx_o
);

    // Index k positions after the pointer, wrapped into 0..N_REQ-1
    function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] p, input int k);
        int j;
        j = int'(p) + k;
        if (j >= N_REQ) begin
            j = j - N_REQ;
        end
        return IW'(j);
    endfunction

    always_comb begin
        found_o  = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        if (lock_i) begin
            if (valid_i[owner_i]) begin
                found_o           = 1'b1;
                onehot_o[owner_i] = 1'b1;
                idx_o             = owner_i;
            end
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!found_o && valid_i[rot_idx(ptr_i, k)]) begin
                    found_o                     = 1'b1;
                    onehot_o[rot_idx(ptr_i, k)] = 1'b1;
                    idx_o                       = rot_idx(ptr_i, k);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one byte-serial UART transmitter between N_REQ
//               requesters with round-robin arbitration and packet locking.
//               A requester keeps the transmitter until it sends a byte
//               flagged last. Transmitter handshake: raise tx_we, wait for
//               tx_ready low, wait for tx_ready high.
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   bus (master)   requester / transmitter handshake bundle
//   grant_o        one-hot current owner (locked or last accepted)
//   busy_o         FSM not idle or lock held
//   timeout_irq_o  one-cycle pulse when a stalled lock is broken
// Build option : UART_ARB_TIMEOUT_EN enables the stalled-lock timeout
//               counter (LOCK_TIMEOUT idle cycles); otherwise locks are
//               held indefinitely and timeout_irq_o is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int LOCK_TIMEOUT = UART_ARB_LOCK_TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    uart_tx_arbiter_if.master        bus,
    output logic [N_REQ-1:0]         grant_o,
    output logic                     busy_o,
    output logic                     timeout_irq_o
);

    localparam int IW = idx_width(N_REQ);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic             lock_q, lock_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_we_q, tx_we_d;

    logic [N_REQ-1:0] req_ready_w;
    logic             accept_w;
    logic             pick_found;
    logic [N_REQ-1:0] pick_onehot;
    logic [IW-1:0]    pick_idx;
    logic [7:0]       pick_byte;

    // Next requester after idx, wrapping; constant 0 for a single requester
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
        if (idx >= IW'(N_REQ - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .valid_i  (bus.req_valid),
        .ptr_i    (ptr_q),
        .lock_i   (lock_q),
        .owner_i  (owner_q),
        .found_o  (pick_found),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx)
    );

    // Byte mux driven by the one-hot winner
    always_comb begin
        pick_byte = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_onehot[i]) begin
                pick_byte = bus.req_data[8*i +: 8];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          irq_q, irq_d;
`else
    // Keeps the timeout parameter referenced when the counter is not built
    logic lock_timeout_unused;
    assign lock_timeout_unused = (LOCK_TIMEOUT > 0);
`endif

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        lock_d      = lock_q;
        grant_d     = grant_q;
        tx_data_d   = tx_data_q;
        req_ready_w = '0;
        accept_w    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Accept happens in the same cycle the winner sees req_ready
                if (bus.tx_ready && pick_found) begin
                    accept_w    = 1'b1;
                    req_ready_w = pick_onehot;
                    tx_data_d   = pick_byte;
                    grant_d     = pick_onehot;
                    owner_d     = pick_idx;
                    lock_d      = !bus.req_last[pick_idx];
                    // Mid-packet bytes leave the pointer where it is
                    if (bus.req_last[pick_idx]) begin
                        ptr_d = wrap_inc(pick_idx);
                    end
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                // Strobe stays up until the transmitter acknowledges by dropping ready
                if (!bus.tx_ready) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef UART_ARB_TIMEOUT_EN
        cnt_d = cnt_q;
        irq_d = 1'b0;
        if (accept_w) begin
            cnt_d = '0;
        end else if ((state_q == ST_IDLE) && lock_q && bus.tx_ready &&
                     !bus.req_valid[owner_q]) begin
            if (cnt_q >= CW'(LOCK_TIMEOUT - 1)) begin
                cnt_d  = '0;
                lock_d = 1'b0;
                ptr_d  = wrap_inc(owner_q);
                irq_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif

        tx_we_d = (state_d == ST_LAUNCH);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            lock_q    <= 1'b0;
            grant_q   <= '0;
            tx_data_q <= 8'h00;
            tx_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            lock_q    <= lock_d;
            grant_q   <= grant_d;
            tx_data_q <= tx_data_d;
            tx_we_q   <= tx_we_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            irq_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            irq_q <= irq_d;
        end
    end

    assign timeout_irq_o = irq_q;
`else
    assign timeout_irq_o = 1'b0;
`endif

    // req_ready is decoded combinationally; masking with rst_n keeps it low
    // while reset is asserted even if a requester is already valid.
    assign bus.req_ready = req_ready_w & {N_REQ{rst_n}};
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_we     = tx_we_q;
    assign grant_o       = grant_q;
    assign busy_o        = (state_q != ST_IDLE) || lock_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter with a
//               transmitter model (ready drops one cycle after tx_we is
//               sampled, rises 12 cycles later; optional extra hold).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N_REQ        = 2;
    localparam int LOCK_TIMEOUT = 16;
    localparam int FRAME        = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

    logic [N_REQ-1:0] grant;
    logic             busy;
    logic             irq;

    uart_tx_arbiter #(
        .N_REQ        (N_REQ),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .grant_o       (grant),
        .busy_o        (busy),
        .timeout_irq_o (irq)
    );

    int errors = 0;
    int checks = 0;

    // ------------------------------------------------------------------
    // Transmitter model and monitors
    // ------------------------------------------------------------------
    logic [7:0] txq[$];
    int         extra_hold = 0;
    int         hold_cnt;
    int         frame_cnt;
    int         acc_cnt[N_REQ];
    int         we_cycles = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.tx_ready <= 1'b1;
            hold_cnt     <= 0;
            frame_cnt    <= 0;
        end else if (bus.tx_ready) begin
            if (bus.tx_we) begin
                if (hold_cnt >= extra_hold) begin
                    bus.tx_ready <= 1'b0;
                    frame_cnt    <= FRAME;
                    hold_cnt     <= 0;
                    txq.push_back(bus.tx_data);
                end else begin
                    hold_cnt <= hold_cnt + 1;
                end
            end else begin
                hold_cnt <= 0;
            end
        end else begin
            if (frame_cnt <= 1) begin
                bus.tx_ready <= 1'b1;
            end
            frame_cnt <= frame_cnt - 1;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                acc_cnt[i] <= acc_cnt[i] + 1;
            end
        end
        if (bus.tx_we) begin
            we_cycles <= we_cycles + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic do_reset();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        extra_hold    = 0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        txq.delete();
        for (int i = 0; i < N_REQ; i++) acc_cnt[i] = 0;
        we_cycles = 0;
    endtask

    // Offer one byte and hold it until accepted
    task automatic send(input int i, input logic [7:0] d, input logic last);
        int t;
        t = 0;
        @(negedge clk);
        bus.req_valid[i]       = 1'b1;
        bus.req_data[8*i +: 8] = d;
        bus.req_last[i]        = last;
        #1;
        while (bus.req_ready[i] !== 1'b1 && t < 2000) begin
            @(negedge clk);
            #1;
            t++;
        end
        checks++;
        if (t >= 2000) begin
            errors++;
            $display("FAIL send_accept: req%0d byte %02h got no accept in %0d cycles, required accept", i, d, t);
            bus.req_valid[i] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.req_valid[i] = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (!(busy === 1'b0 && bus.tx_ready === 1'b1) && t < 500) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 500) begin
            errors++;
            $display("FAIL wait_idle: busy=%b tx_ready=%b after %0d cycles, required 0/1", busy, bus.tx_ready, t);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        @(negedge clk);
        bus.req_valid[0]   = 1'b1;
        bus.req_data[7:0]  = 8'h33;
        bus.req_last[0]    = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b required 00", bus.req_ready); end
        checks++; if (bus.tx_we !== 1'b0)      begin errors++; $display("FAIL reset_tx_we: got %b required 0", bus.tx_we); end
        checks++; if (bus.tx_data !== 8'h00)   begin errors++; $display("FAIL reset_tx_data: got %02h required 00", bus.tx_data); end
        checks++; if (grant !== 2'b00)         begin errors++; $display("FAIL reset_grant: got %b required 00", grant); end
        checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (irq !== 1'b0)            begin errors++; $display("FAIL reset_irq: got %b required 0", irq); end
        repeat (3) @(negedge clk);
        checks++; if (bus.req_ready !== 2'b00 || bus.tx_we !== 1'b0) begin
            errors++; $display("FAIL reset_hold: req_ready=%b tx_we=%b required 00/0", bus.req_ready, bus.tx_we);
        end
        bus.req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        send(0, 8'h41, 1'b1);
        checks++; if (bus.tx_we !== 1'b1) begin errors++; $display("FAIL single_we_latency: got %b required 1", bus.tx_we); end
        checks++; if (grant !== 2'b01)    begin errors++; $display("FAIL single_grant: got %b required 01", grant); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL single_busy: got %b required 1", busy); end
        wait_idle();
        checks++; if (txq.size() !== 1)   begin errors++; $display("FAIL single_count: got %0d bytes required 1", txq.size()); end
        checks++; if (txq.size() < 1 || txq[0] !== 8'h41) begin errors++; $display("FAIL single_data: got %02h required 41", (txq.size() > 0) ? txq[0] : 8'hxx); end
        checks++; if (acc_cnt[0] !== 1)   begin errors++; $display("FAIL single_accepts: got %0d required 1", acc_cnt[0]); end
        checks++; if (we_cycles !== 2)    begin errors++; $display("FAIL single_we_cycles: got %0d required 2", we_cycles); end
        // Pointer moved to 1: with both offering, requester 1 goes first
        txq.delete();
        fork
            send(0, 8'h50, 1'b1);
            send(1, 8'h61, 1'b1);
        join
        wait_idle();
        checks++; if (txq.size() !== 2 || txq[0] !== 8'h61 || txq[1] !== 8'h50) begin
            errors++; $display("FAIL single_pointer: got %0d bytes first %02h required 61 then 50", txq.size(), (txq.size() > 0) ? txq[0] : 8'hxx);
        end
    endtask

    task automatic test_contention();
        logic [7:0] exp_q[6];
        exp_q = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
        do_reset();
        fork
            begin for (int k = 0; k < 3; k++) send(0, 8'h10 + 8'(k), 1'b1); end
            begin for (int k = 0; k < 3; k++) send(1, 8'h20 + 8'(k), 1'b1); end
        join
        wait_idle();
        checks++; if (txq.size() !== 6) begin errors++; $display("FAIL contention_count: got %0d required 6", txq.size()); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (k >= txq.size() || txq[k] !== exp_q[k]) begin
                errors++; $display("FAIL contention_order[%0d]: got %02h required %02h", k, (k < txq.size()) ? txq[k] : 8'hxx, exp_q[k]);
            end
        end
    endtask

    task automatic test_lock();
        logic [7:0] exp_q[4];
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};
        do_reset();
        fork
            begin
                send(0, 8'hA0, 1'b0);
                checks++; if (grant !== 2'b01) begin errors++; $display("FAIL lock_grant_a0: got %b required 01", grant); end
                send(0, 8'hA1, 1'b0);
                checks++; if (grant !== 2'b01) begin errors++; $display("FAIL lock_grant_a1: got %b required 01", grant); end
                send(0, 8'hA2, 1'b1);
                checks++; if (grant !== 2'b01) begin errors++; $display("FAIL lock_grant_a2: got %b required 01", grant); end
            end
            send(1, 8'hB0, 1'b1);
        join
        wait_idle();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k >= txq.size() || txq[k] !== exp_q[k]) begin
                errors++; $display("FAIL lock_order[%0d]: got %02h required %02h", k, (k < txq.size()) ? txq[k] : 8'hxx, exp_q[k]);
            end
        end
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL lock_grant_b0: got %b required 10", grant); end
    endtask

    task automatic test_handshake();
        do_reset();
        extra_hold = 3;
        send(0, 8'h5A, 1'b1);
        wait_idle();
        extra_hold = 0;
        // ready stays high for 3 extra sampled cycles, then one more cycle to see it low
        checks++; if (we_cycles !== 5)  begin errors++; $display("FAIL handshake_we_cycles: got %0d required 5", we_cycles); end
        checks++; if (txq.size() !== 1) begin errors++; $display("FAIL handshake_count: got %0d required 1", txq.size()); end
        checks++; if (txq.size() < 1 || txq[0] !== 8'h5A) begin errors++; $display("FAIL handshake_data: got %02h required 5A", (txq.size() > 0) ? txq[0] : 8'hxx); end
        checks++; if (acc_cnt[0] !== 1) begin errors++; $display("FAIL handshake_accepts: got %0d required 1", acc_cnt[0]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(1, 8'h77, 1'b1);
        checks++; if (bus.tx_we !== 1'b1) begin errors++; $display("FAIL rstmid_pre_we: got %b required 1", bus.tx_we); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.tx_we !== 1'b0)    begin errors++; $display("FAIL rstmid_tx_we: got %b required 0", bus.tx_we); end
        checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_tx_data: got %02h required 00", bus.tx_data); end
        checks++; if (grant !== 2'b00)       begin errors++; $display("FAIL rstmid_grant: got %b required 00", grant); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL rstmid_busy: got %b required 0", busy); end
        checks++; if (txq.size() !== 0)      begin errors++; $display("FAIL rstmid_no_byte: got %0d bytes required 0", txq.size()); end
        @(negedge clk);
        rst_n = 1'b1;
        fork
            send(1, 8'h99, 1'b1);
            send(0, 8'h88, 1'b1);
        join
        wait_idle();
        checks++; if (txq.size() !== 2 || txq[0] !== 8'h88 || txq[1] !== 8'h99) begin
            errors++; $display("FAIL rstmid_order: got %0d bytes first %02h required 88 then 99", txq.size(), (txq.size() > 0) ? txq[0] : 8'hxx);
        end
    endtask

    task automatic test_timeout();
        int n;
        int t;
        logic saw_irq;
        do_reset();
        send(0, 8'hC0, 1'b0);
        fork
            send(1, 8'hD0, 1'b1);
            begin
`ifdef UART_ARB_TIMEOUT_EN
                t = 0;
                while (bus.tx_ready !== 1'b0 && t < 50) begin @(negedge clk); t++; end
                while (bus.tx_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
                // n = 1 is the DRAIN cycle that sees ready high; idle cycles follow
                n = 1;
                while (irq !== 1'b1 && n < 100) begin @(negedge clk); n++; end
                checks++; if (n !== 18) begin errors++; $display("FAIL timeout_irq_cycle: got ready-high cycle %0d required 18", n); end
                @(negedge clk);
                checks++; if (irq !== 1'b0) begin errors++; $display("FAIL timeout_irq_pulse: got %b one cycle later required 0", irq); end
`else
                saw_irq = 1'b0;
                repeat (200) begin
                    @(negedge clk);
                    if (irq !== 1'b0) saw_irq = 1'b1;
                end
                checks++; if (acc_cnt[1] !== 0) begin errors++; $display("FAIL nolock_starve: req1 accepts got %0d required 0", acc_cnt[1]); end
                checks++; if (saw_irq !== 1'b0) begin errors++; $display("FAIL nolock_irq: got %b required 0", saw_irq); end
                checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL nolock_busy: got %b required 1", busy); end
                send(0, 8'hC1, 1'b1);
`endif
            end
        join
        wait_idle();
`ifdef UART_ARB_TIMEOUT_EN
        checks++; if (txq.size() !== 2 || txq[0] !== 8'hC0 || txq[1] !== 8'hD0) begin
            errors++; $display("FAIL timeout_order: got %0d bytes last %02h required C0 then D0", txq.size(), (txq.size() > 0) ? txq[txq.size()-1] : 8'hxx);
        end
`else
        checks++; if (txq.size() !== 3 || txq[0] !== 8'hC0 || txq[1] !== 8'hC1 || txq[2] !== 8'hD0) begin
            errors++; $display("FAIL nolock_order: got %0d bytes last %02h required C0 C1 D0", txq.size(), (txq.size() > 0) ? txq[txq.size()-1] : 8'hxx);
        end
`endif
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        for (int i = 0; i < N_REQ; i++) acc_cnt[i] = 0;
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_handshake();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
